// File: rtl/cpu_run_pkg.sv
// Shared types and defaults for the processor run controller.
package cpu_run_pkg;

  // Controller states, encoded in the state register that all outputs decode from.
  typedef enum logic [2:0] {
    RST_HOLD,
    IDLE,
    RUN,
    STEP_WAIT,
    STEP_EXEC,
    DONE
  } run_state_t;

  // Default number of cycles the processor reset is held after the pin reset falls.
  localparam int unsigned DEF_RST_CYCLES = 4;

endpackage

// File: rtl/rst_stretch.sv
// Stretches the pin reset so the processor sees it for RST_CYCLES more cycles.
module rst_stretch
  import cpu_run_pkg::*;
#(
  parameter int unsigned RST_CYCLES = DEF_RST_CYCLES
) (
  input  logic clk,
  input  logic reset,
  output logic rst_o
);

  // One extra bit so RST_CYCLES=1 still yields a non-zero counter width.
  localparam int unsigned CW = $clog2(RST_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(RST_CYCLES - 1);

  logic [CW-1:0] hold_q;
  logic [CW-1:0] hold_d;

  // Count up after reset falls and park at the terminal value until the next reset.
  always_comb begin
    hold_d = hold_q;
    if (hold_q != LAST) begin
      hold_d = hold_q + 1'b1;
    end
  end

  // Hold counter register; cleared for as long as reset is high.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end

  // Released in the cycle the counter sits at its terminal value with reset low.
  assign rst_o = reset | (hold_q != LAST);

endmodule

// File: rtl/cpu_run_ctrl.sv
// Sequences processor reset and a counted continuous or single-stepped run.
module cpu_run_ctrl
  import cpu_run_pkg::*;
#(
  parameter int unsigned RST_CYCLES = DEF_RST_CYCLES,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mode_step,
  input  logic             step,
  input  logic [CNT_W-1:0] run_len,
  input  logic             halt_req,
  output logic             cpu_reset,
  output logic             cpu_en,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] cycle_cnt
);

  run_state_t       state_q, state_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             step_q, step_d;
  logic             hold_rst;
  logic             last_cycle;

  rst_stretch #(
    .RST_CYCLES(RST_CYCLES)
  ) u_rst_stretch (
    .clk  (clk),
    .reset(reset),
    .rst_o(hold_rst)
  );

  // A zero run length means free-run, so it never terminates on count.
  assign last_cycle = (len_q != '0) && (cnt_q == len_q - 1'b1);

  // Next-state and datapath updates for the run sequence.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    step_d  = step_q;
    cnt_d   = cnt_q;
    case (state_q)
      RST_HOLD: begin
        if (!hold_rst) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        if (start) begin
          len_d   = run_len;
          step_d  = mode_step;
          cnt_d   = '0;
          state_d = mode_step ? STEP_WAIT : RUN;
        end
      end
      RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (last_cycle || halt_req) begin
          state_d = DONE;
        end
      end
      STEP_WAIT: begin
        if (halt_req) begin
          state_d = DONE;
        end else if (step) begin
          state_d = STEP_EXEC;
        end
      end
      STEP_EXEC: begin
        cnt_d   = cnt_q + 1'b1;
        state_d = last_cycle ? DONE : STEP_WAIT;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = RST_HOLD;
      end
    endcase
  end

  // State and run registers; reset aborts any run without a done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RST_HOLD;
      len_q   <= '0;
      step_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
    end
  end

  assign cpu_reset = (state_q == RST_HOLD);
  assign cpu_en    = (state_q == RUN) || (state_q == STEP_EXEC);
  assign busy      = (state_q == RUN) || (state_q == STEP_WAIT) || (state_q == STEP_EXEC);
  assign done      = (state_q == DONE);
  assign cycle_cnt = cnt_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Scenario bench for cpu_run_ctrl; expected done counts go through a scoreboard queue.
module tb_cpu_run_ctrl;

  localparam int CNT_W = 4;
  localparam int RSTC  = 4;

  logic             clk = 1'b0;
  logic             reset, start, mode_step, step, halt_req;
  logic [CNT_W-1:0] run_len;
  logic             cpu_reset, cpu_en, busy, done;
  logic [CNT_W-1:0] cycle_cnt;

  int checks = 0;
  int failures = 0;
  int en_total = 0;
  int done_total = 0;
  logic [CNT_W-1:0] exp_q[$];

  always #5 clk = ~clk;

  cpu_run_ctrl #(
    .RST_CYCLES(RSTC),
    .CNT_W     (CNT_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .mode_step(mode_step),
    .step     (step),
    .run_len  (run_len),
    .halt_req (halt_req),
    .cpu_reset(cpu_reset),
    .cpu_en   (cpu_en),
    .busy     (busy),
    .done     (done),
    .cycle_cnt(cycle_cnt)
  );

  // Monitor: counts enabled cycles and scores every done pulse against the queue.
  always @(negedge clk) begin
    logic [CNT_W-1:0] e;
    if (cpu_en === 1'b1) en_total++;
    if (done === 1'b1) begin
      done_total++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL done_unexpected cycle_cnt=%0d expected no done", cycle_cnt);
      end else begin
        e = exp_q.pop_front();
        if (cycle_cnt !== e) begin
          failures++;
          $display("FAIL done_cycle_cnt got=%0d exp=%0d", cycle_cnt, e);
        end else begin
          $display("done pulse cycle_cnt=%0d ok", cycle_cnt);
        end
      end
    end
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    int hi, bad;
    reset = 1'b1;
    cyc();
    cyc();
    checks++;
    if ({cpu_reset, cpu_en, busy, done} !== 4'b1000 || cycle_cnt !== 4'd0) begin
      failures++;
      $display("FAIL reset_values got=%b cnt=%0d exp=1000 cnt=0", {cpu_reset, cpu_en, busy, done}, cycle_cnt);
    end
    reset = 1'b0;
    hi = 1;
    bad = 0;
    for (int i = 0; i < 20 && cpu_reset === 1'b1; i++) begin
      cyc();
      if (cpu_reset === 1'b1) hi++;
      if (cpu_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0) bad++;
    end
    checks++;
    if (hi != RSTC) begin
      failures++;
      $display("FAIL reset_hold_len got=%0d exp=%0d", hi, RSTC);
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL reset_outputs_quiet got=%0d exp=0", bad);
    end
    $display("reset: cpu_reset held %0d cycles", hi);
  endtask

  task automatic test_continuous();
    int en0, d0, mism;
    logic seen;
    en0 = en_total;
    d0 = done_total;
    start = 1'b1;
    mode_step = 1'b0;
    run_len = 4'd13;
    exp_q.push_back(4'd13);
    cyc();
    start = 1'b0;
    run_len = 4'($urandom_range(15, 0));
    checks++;
    if (busy !== 1'b1 || cpu_en !== 1'b1) begin
      failures++;
      $display("FAIL cont_first_cycle busy=%b en=%b exp=1 1", busy, cpu_en);
    end
    mism = 0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      cyc();
      if (busy !== cpu_en) mism++;
      if (done === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL cont_done_timeout got=0 exp=1");
    end
    checks++;
    if (en_total - en0 != 13) begin
      failures++;
      $display("FAIL cont_en_cycles got=%0d exp=13", en_total - en0);
    end
    checks++;
    if (done_total - d0 != 1 || mism != 0) begin
      failures++;
      $display("FAIL cont_done_busy dones=%0d mism=%0d exp=1 0", done_total - d0, mism);
    end
    cyc();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || cycle_cnt !== 4'd13) begin
      failures++;
      $display("FAIL cont_idle_hold busy=%b done=%b cnt=%0d exp=0 0 13", busy, done, cycle_cnt);
    end
    $display("continuous: run_len=13 enabled=%0d", en_total - en0);
  endtask

  task automatic test_step();
    int en0, d0, perr;
    en0 = en_total;
    d0 = done_total;
    start = 1'b1;
    mode_step = 1'b1;
    run_len = 4'd3;
    exp_q.push_back(4'd3);
    cyc();
    start = 1'b0;
    mode_step = 1'b0;
    perr = 0;
    if (busy !== 1'b1 || cpu_en !== 1'b0) perr++;
    for (int i = 0; i < 3; i++) begin
      step = 1'b1;
      cyc();
      step = 1'b0;
      if (cpu_en !== 1'b1) perr++;
      cyc();
      if (cpu_en !== 1'b0) perr++;
      if (i == 2 && done !== 1'b1) perr++;
      if (i < 2) cyc();
    end
    checks++;
    if (perr != 0) begin
      failures++;
      $display("FAIL step_pulses errors=%0d exp=0", perr);
    end
    cyc();
    step = 1'b1;
    cyc();
    step = 1'b0;
    checks++;
    if (busy !== 1'b0 || cpu_en !== 1'b0 || cycle_cnt !== 4'd3) begin
      failures++;
      $display("FAIL step_idle_ignored busy=%b en=%b cnt=%0d exp=0 0 3", busy, cpu_en, cycle_cnt);
    end
    cyc();
    checks++;
    if (en_total - en0 != 3 || done_total - d0 != 1) begin
      failures++;
      $display("FAIL step_totals en=%0d dones=%0d exp=3 1", en_total - en0, done_total - d0);
    end
    $display("step: three steps, enabled=%0d", en_total - en0);
  endtask

  task automatic test_freerun();
    int en0;
    logic wrap;
    logic [CNT_W-1:0] prev;
    en0 = en_total;
    start = 1'b1;
    mode_step = 1'b0;
    run_len = 4'd0;
    exp_q.push_back(4'd4);
    cyc();
    start = 1'b0;
    prev = cycle_cnt;
    wrap = 1'b0;
    for (int i = 0; i < 19; i++) begin
      cyc();
      if (prev == 4'd15 && cycle_cnt == 4'd0) wrap = 1'b1;
      prev = cycle_cnt;
    end
    checks++;
    if (!wrap || busy !== 1'b1 || cycle_cnt !== 4'd3) begin
      failures++;
      $display("FAIL free_wrap wrap=%b busy=%b cnt=%0d exp=1 1 3", wrap, busy, cycle_cnt);
    end
    halt_req = 1'b1;
    cyc();
    halt_req = 1'b0;
    checks++;
    if (done !== 1'b1 || cpu_en !== 1'b0 || en_total - en0 != 20) begin
      failures++;
      $display("FAIL free_halt done=%b en=%b enabled=%0d exp=1 0 20", done, cpu_en, en_total - en0);
    end
    cyc();
    $display("freerun: halted after %0d enabled cycles cnt=%0d", en_total - en0, cycle_cnt);
  endtask

  task automatic test_reset_midrun();
    int d0;
    logic rel;
    d0 = done_total;
    start = 1'b1;
    run_len = 4'd13;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 4; i++) cyc();
    reset = 1'b1;
    cyc();
    checks++;
    if (cpu_en !== 1'b0 || cpu_reset !== 1'b1 || cycle_cnt !== 4'd0 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL midrun_reset en=%b rst=%b cnt=%0d busy=%b done=%b exp=0 1 0 0 0",
               cpu_en, cpu_reset, cycle_cnt, busy, done);
    end
    reset = 1'b0;
    rel = 1'b0;
    for (int i = 0; i < 20 && !rel; i++) begin
      cyc();
      if (cpu_reset === 1'b0) rel = 1'b1;
    end
    cyc();
    cyc();
    checks++;
    if (!rel || done_total != d0) begin
      failures++;
      $display("FAIL midrun_recover released=%b dones=%0d exp=1 0", rel, done_total - d0);
    end
    $display("reset_midrun: aborted run, released=%b", rel);
  endtask

  task automatic test_ignored();
    int en0, d0;
    logic seen;
    en0 = en_total;
    start = 1'b1;
    mode_step = 1'b0;
    run_len = 4'd6;
    exp_q.push_back(4'd6);
    cyc();
    start = 1'b0;
    cyc();
    start = 1'b1;
    mode_step = 1'b1;
    run_len = 4'd2;
    cyc();
    start = 1'b0;
    mode_step = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      cyc();
      if (done === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen || en_total - en0 != 6) begin
      failures++;
      $display("FAIL start_in_run seen=%b enabled=%0d exp=1 6", seen, en_total - en0);
    end
    cyc();
    en0 = en_total;
    start = 1'b1;
    mode_step = 1'b1;
    run_len = 4'd5;
    exp_q.push_back(4'd1);
    cyc();
    start = 1'b0;
    mode_step = 1'b0;
    step = 1'b1;
    cyc();
    step = 1'b0;
    cyc();
    halt_req = 1'b1;
    step = 1'b1;
    cyc();
    halt_req = 1'b0;
    step = 1'b0;
    checks++;
    if (cpu_en !== 1'b0 || done !== 1'b1 || en_total - en0 != 1) begin
      failures++;
      $display("FAIL halt_over_step en=%b done=%b enabled=%0d exp=0 1 1", cpu_en, done, en_total - en0);
    end
    cyc();
    d0 = done_total;
    halt_req = 1'b1;
    cyc();
    cyc();
    halt_req = 1'b0;
    checks++;
    if (busy !== 1'b0 || done_total != d0 || cycle_cnt !== 4'd1) begin
      failures++;
      $display("FAIL halt_in_idle busy=%b dones=%0d cnt=%0d exp=0 0 1", busy, done_total - d0, cycle_cnt);
    end
    $display("ignored: start in RUN, halt beats step, idle halt");
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    mode_step = 1'b0;
    step = 1'b0;
    halt_req = 1'b0;
    run_len = '0;
    test_reset();
    test_continuous();
    test_step();
    test_freerun();
    test_reset_midrun();
    test_ignored();
    cyc();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain left=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Run controller that sequences the processor's reset and execution. It holds `processor` in reset after power-up, then on command enables it for an exact programmed number of cycles, either continuously or single-stepped. It sits between the top-level clock/reset pins and the processor's `reset` and clock-enable, and replaces hand-toggled bench stimulus with a deterministic, countable run.

## Interface
Parameters:
- `RST_CYCLES`, default 4: cycles `cpu_reset` stays high after `reset` deasserts; legal range ≥1.
- `CNT_W`, default 16: width of the run length and cycle counter.

Ports:
- `clk` in 1: single clock; all logic is on the rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: begin a run; sampled only in IDLE.
- `mode_step` in 1: latched with `start`. 0 = continuous, 1 = single-step.
- `step` in 1: advance one cycle; sampled only in STEP_WAIT.
- `run_len` in CNT_W: number of enabled cycles, latched with `start`. 0 = free-run until halt.
- `halt_req` in 1: stop the run early; sampled in RUN and STEP_WAIT.
- `cpu_reset` out 1: reset to the processor.
- `cpu_en` out 1: clock-enable to the processor.
- `busy` out 1: a run is in progress.
- `done` out 1: one-cycle pulse when a run ends.
- `cycle_cnt` out CNT_W: number of enabled cycles in the current or last run.

## Operation
- The FSM states are RST_HOLD, IDLE, RUN, STEP_WAIT, STEP_EXEC, DONE.
- All outputs are registered or decoded from the state register (Moore outputs):
  - `cpu_reset` is 1 only in RST_HOLD.
  - `cpu_en` is 1 in RUN and STEP_EXEC.
  - `busy` is 1 in RUN, STEP_WAIT and STEP_EXEC.
  - `done` is 1 only in DONE.
- Reset values: state RST_HOLD, `cpu_reset`=1, `cpu_en`=0, `busy`=0, `done`=0, `cycle_cnt`=0, hold counter 0.
- RST_HOLD:
  - While `reset`=1, the hold counter is cleared.
  - Once `reset`=0, the hold counter increments.
  - Transition to IDLE on the cycle the counter reaches RST_CYCLES-1.
- IDLE: on `start`, latch `len_q`←`run_len` and `step_q`←`mode_step`, clear `cycle_cnt`, then go to RUN if `step_q`=0, else STEP_WAIT.
- RUN:
  - `cycle_cnt` increments every cycle.
  - Go to DONE when `len_q`≠0 and `cycle_cnt`==`len_q`-1, or when `halt_req`=1.
  - The cycle in which halt is sampled is still enabled and counted.
- STEP_WAIT:
  - `halt_req` goes to DONE; `halt_req` has priority over `step`.
  - Otherwise `step` goes to STEP_EXEC.
- STEP_EXEC:
  - `cycle_cnt` increments.
  - Go to DONE if `len_q`≠0 and `cycle_cnt`==`len_q`-1; otherwise return to STEP_WAIT.
- DONE: go to IDLE unconditionally. `cycle_cnt` holds its value until the next `start`.
- Width rules: `cycle_cnt` is modulo 2^CNT_W. In free-run it wraps to 0 with no flag. The `len_q` comparison is exact and unsigned.
- Boundary conditions:
  - `start` outside IDLE is ignored.
  - `step` outside STEP_WAIT is ignored.
  - `halt_req` in IDLE or DONE is ignored.
  - `reset`=1 in any state forces RST_HOLD and the reset values on the next edge, including mid-run. No `done` pulse is produced for an aborted run.

## Timing
- With `start` sampled at edge k in continuous mode:
  - `cpu_en` and `busy` are high for exactly `len_q` cycles, from edge k+1 through edge k+`len_q`.
  - `done` is high for one cycle after edge k+`len_q`+1.
  - `cycle_cnt`=`len_q` while `done` is high.
- Step mode: a `step` sampled at edge j gives `cpu_en`=1 for exactly one cycle, after edge j+1. The earliest the next step can be accepted is edge j+2.
- `halt_req` sampled at edge h in RUN: `cpu_en` drops after edge h+1 and `done` is high for the cycle following edge h+1.
- After `reset` falls: `cpu_reset` stays high for RST_CYCLES cycles, and `start` is accepted from the following edge.

## Structure
- Package `cpu_run_pkg` holds:
  - enum `run_state_t` {RST_HOLD, IDLE, RUN, STEP_WAIT, STEP_EXEC, DONE};
  - localparam default `RST_CYCLES`.
- A sub-module `rst_stretch` (reset input → stretched reset output, parameter `RST_CYCLES`) is natural. It owns the hold counter and feeds the RST_HOLD→IDLE exit.
- The main module holds the FSM, `len_q`, `step_q` and `cycle_cnt`.

## Test plan
- Power-up, RST_CYCLES=4: `reset` high 2 cycles then low → `cpu_reset` high for 4 cycles after the fall, then 0; all other outputs 0 throughout.
- Continuous run, `run_len`=13, `start` pulse → `cpu_en` high for exactly 13 cycles, one `done` pulse, `cycle_cnt`=13, `busy` falls with `cpu_en`.
- Step mode, `run_len`=3, `step` pulsed 3 times with 2-cycle gaps → three 1-cycle `cpu_en` pulses, `done` after the third, `cycle_cnt`=3. An extra `step` in IDLE has no effect.
- Free-run with `run_len`=0 and CNT_W=4 → `cycle_cnt` wraps 15→0. `halt_req` after 20 enabled cycles → `cycle_cnt`=4 (with the halt-sample cycle counted), one `done` pulse.
- `reset` asserted at cycle 5 of a 13-cycle run → `cpu_en`=0 and `cpu_reset`=1 on the next edge, `cycle_cnt`=0, no `done`.
- `start` in RUN, and `halt_req`+`step` together in STEP_WAIT → the `start` is ignored; halt wins, with no STEP_EXEC cycle.
